if_stage_ctrl: RTL and testbench

- Fetch-side responder to the ID-stage load-use hazard/bubble detector in the five-stage RV32I pipeline.
- Owns the PC register and the IF/ID pipeline register.
- Acts on hold requests (the PCdelay output of the hazard detector) and on EX-stage branch/jump flush requests.
- Runs the halt-drain sequence: when the halt opcode 7'b1111111 is fetched, fetch freezes, the downstream stages drain for a fixed count, then `halted` asserts.

---
 rtl/if_stage_ctrl_if.sv | 26 ++
 rtl/if_stage_ctrl.sv | 104 ++++++++++
 tb/tb_if_stage_ctrl.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/if_stage_ctrl_if.sv
// if_stage_ctrl_if: fetch-side bundle between the hazard unit, imem and IF/ID.
// Ports: stall/flush/redirect in, imem addr/rdata, IF/ID regs, halted, state_dbg.
interface if_stage_ctrl_if;
  logic        stall_req;
  logic        flush_req;
  logic [31:0] redirect_pc;
  logic [31:0] imem_rdata;
  logic [31:0] imem_addr;
  logic [31:0] ifid_inst;
  logic [31:0] ifid_pc;
  logic        ifid_valid;
  logic        halted;
  logic [1:0]  state_dbg;

  modport master (
    output stall_req, flush_req, redirect_pc, imem_rdata,
    input  imem_addr, ifid_inst, ifid_pc, ifid_valid,
    input  halted, state_dbg
  );

  modport slave (
    input  stall_req, flush_req, redirect_pc, imem_rdata,
    output imem_addr, ifid_inst, ifid_pc, ifid_valid,
    output halted, state_dbg
  );
endinterface

// File: rtl/if_stage_ctrl.sv
// if_stage_ctrl: PC + IF/ID register, stall/flush response, halt drain FSM.
// Ports: CLK, Reset (sync, active-high), bus (if_stage_ctrl_if.slave).
module if_stage_ctrl #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          DRAIN_CYCLES = 4,
  parameter logic [31:0] NOP_INST     = 32'h0000_0013
) (
  input  logic          CLK,
  input  logic          Reset,
  if_stage_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2,
    BAD    = 2'd3
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(DRAIN_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] ipc_q, ipc_d;
  logic        vld_q, vld_d;
  logic        halt_word;

  assign halt_word = bus.imem_rdata[6:0] == 7'h7f;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
      pc_q    <= RESET_PC;
      inst_q  <= NOP_INST;
      ipc_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      ipc_q   <= ipc_d;
      vld_q   <= vld_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    ipc_d   = ipc_q;
    vld_d   = vld_q;
    unique case (state_q)
      RUN, DRAIN: begin
        if (bus.flush_req) begin
          // redirect also cancels any wrong-path halt drain
          pc_d    = {bus.redirect_pc[31:2], 2'b00};
          inst_d  = NOP_INST;
          ipc_d   = '0;
          vld_d   = 1'b0;
          state_d = RUN;
          cnt_d   = '0;
        end else if (!bus.stall_req) begin
          if (state_q == RUN) begin
            inst_d = bus.imem_rdata;
            ipc_d  = pc_q;
            vld_d  = 1'b1;
            if (halt_word) begin
              state_d = DRAIN;
              cnt_d   = '0;
            end else begin
              pc_d = pc_q + 32'd4;
            end
          end else begin
            inst_d = NOP_INST;
            vld_d  = 1'b0;
            cnt_d  = cnt_q + 4'd1;
            if (cnt_q == CNT_LAST) begin
              state_d = HALTED;
            end
          end
        end
      end
      HALTED: begin
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  assign bus.imem_addr  = pc_q;
  assign bus.ifid_inst  = inst_q;
  assign bus.ifid_pc    = ipc_q;
  assign bus.ifid_valid = vld_q;
  assign bus.halted     = state_q == HALTED;
  assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_if_stage_ctrl.sv
// tb_if_stage_ctrl: directed + random checks of if_stage_ctrl against a model.
// Ports: none; drives if_stage_ctrl_if and a combinational instruction ROM.
module tb_if_stage_ctrl;
  localparam int DC = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] FILL = 32'h0010_0093;

  logic CLK = 1'b0;
  logic Reset;
  always #5 CLK = ~CLK;

  if_stage_ctrl_if bus ();

  if_stage_ctrl #(
    .RESET_PC(32'h0),
    .DRAIN_CYCLES(DC),
    .NOP_INST(NOP)
  ) dut (
    .CLK(CLK),
    .Reset(Reset),
    .bus(bus)
  );

  logic        rand_mode;
  logic        halt_en;
  logic [31:0] halt_at;
  logic [31:0] rom [64];
  logic [31:0] rd;

  always_comb begin
    if (rand_mode) rd = rom[bus.imem_addr[7:2]];
    else if (halt_en && bus.imem_addr == halt_at) rd = 32'h0000_007f;
    else rd = FILL;
  end
  assign bus.imem_rdata = rd;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (rand_mode) return rom[a[7:2]];
    if (halt_en && a == halt_at) return 32'h0000_007f;
    return FILL;
  endfunction

  // reference model: draining counts down the remaining bubble cycles
  logic [31:0] m_pc, m_inst, m_ipc;
  logic        m_valid, m_halted, m_draining;
  int          m_left;

  int total = 0;
  int pass_cnt = 0;
  int fail_cnt = 0;

  task automatic model_step(input logic [31:0] rdata);
    if (Reset) begin
      m_pc = 0; m_inst = NOP; m_ipc = 0; m_valid = 0;
      m_halted = 0; m_draining = 0; m_left = 0;
    end else if (m_halted) begin
    end else if (bus.flush_req) begin
      m_pc = bus.redirect_pc & ~32'd3;
      m_inst = NOP; m_ipc = 0; m_valid = 0; m_draining = 0;
    end else if (bus.stall_req) begin
    end else if (m_draining) begin
      m_inst = NOP; m_valid = 0;
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_halted = 1; m_draining = 0;
      end
    end else begin
      m_inst = rdata; m_ipc = m_pc; m_valid = 1;
      if (rdata[6:0] == 7'h7f) begin
        m_draining = 1; m_left = DC;
      end else begin
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [31:0] st;
    st = m_halted ? 32'd2 : (m_draining ? 32'd1 : 32'd0);
    chk({tag, ".addr"}, bus.imem_addr, m_pc);
    chk({tag, ".inst"}, bus.ifid_inst, m_inst);
    chk({tag, ".ipc"}, bus.ifid_pc, m_ipc);
    chk({tag, ".valid"}, 32'(bus.ifid_valid), 32'(m_valid));
    chk({tag, ".halted"}, 32'(bus.halted), 32'(m_halted));
    chk({tag, ".state"}, 32'(bus.state_dbg), st);
  endtask

  task automatic tick(input string tag);
    model_step(mem_word(m_pc));
    @(posedge CLK);
    #1;
    check_all(tag);
  endtask

  task automatic set_in(input logic r, input logic s, input logic f,
                        input logic [31:0] rp);
    Reset = r;
    bus.stall_req = s;
    bus.flush_req = f;
    bus.redirect_pc = rp;
  endtask

  initial begin
    rand_mode = 0;
    halt_en = 0;
    halt_at = 32'h14;
    for (int i = 0; i < 64; i++) rom[i] = FILL;
    m_pc = 0; m_inst = NOP; m_ipc = 0; m_valid = 0;
    m_halted = 0; m_draining = 0; m_left = 0;
    set_in(1, 0, 0, 0);
    #1;

    // reset values
    tick("rst");
    chk("rst.addr0", bus.imem_addr, 32'h0);
    chk("rst.nop", bus.ifid_inst, NOP);
    chk("rst.valid0", 32'(bus.ifid_valid), 32'd0);
    chk("rst.state0", 32'(bus.state_dbg), 32'd0);

    // free run
    set_in(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) tick("run");
    chk("run4.addr", bus.imem_addr, 32'h10);
    chk("run4.ipc", bus.ifid_pc, 32'hc);
    chk("run4.valid", 32'(bus.ifid_valid), 32'd1);

    // stall at 0x8
    set_in(1, 0, 0, 0); tick("rst2");
    set_in(0, 0, 0, 0); tick("s0"); tick("s1");
    set_in(0, 1, 0, 0);
    for (int i = 0; i < 2; i++) begin
      tick("stall");
      chk("stall.addr", bus.imem_addr, 32'h8);
      chk("stall.ipc", bus.ifid_pc, 32'h4);
    end
    set_in(0, 0, 0, 0); tick("unstall");
    chk("unstall.addr", bus.imem_addr, 32'hc);
    chk("unstall.ipc", bus.ifid_pc, 32'h8);

    // flush beats stall
    set_in(0, 1, 1, 32'h103); tick("fs");
    chk("fs.addr", bus.imem_addr, 32'h100);
    chk("fs.inst", bus.ifid_inst, NOP);
    chk("fs.valid", 32'(bus.ifid_valid), 32'd0);

    // halt drain with one stall
    halt_en = 1;
    set_in(1, 0, 0, 0); tick("rst3");
    set_in(0, 0, 0, 0);
    for (int i = 0; i < 6; i++) tick("toh");
    chk("hcap.inst", bus.ifid_inst, 32'h7f);
    chk("hcap.state", 32'(bus.state_dbg), 32'd1);
    tick("d1");
    set_in(0, 1, 0, 0); tick("d2");
    set_in(0, 0, 0, 0); tick("d3"); tick("d4");
    chk("d4.halted", 32'(bus.halted), 32'd0);
    tick("d5");
    chk("d5.halted", 32'(bus.halted), 32'd1);
    chk("d5.addr", bus.imem_addr, 32'h14);
    set_in(0, 0, 1, 32'h40); tick("hflush");
    chk("hflush.addr", bus.imem_addr, 32'h14);
    chk("hflush.state", 32'(bus.state_dbg), 32'd2);

    // wrong-path halt
    set_in(1, 0, 0, 0); tick("rst4");
    set_in(0, 0, 0, 0);
    for (int i = 0; i < 6; i++) tick("toh2");
    tick("wd1");
    set_in(0, 0, 1, 32'h40); tick("wflush");
    chk("wp.state", 32'(bus.state_dbg), 32'd0);
    chk("wp.halted", 32'(bus.halted), 32'd0);
    chk("wp.addr", bus.imem_addr, 32'h40);
    set_in(0, 0, 0, 0); tick("wres");
    chk("wres.ipc", bus.ifid_pc, 32'h40);

    // wrap
    set_in(0, 0, 1, 32'hffff_fffe); tick("wf");
    set_in(0, 0, 0, 0); tick("wrap");
    chk("wrap.addr", bus.imem_addr, 32'h0);
    chk("wrap.ipc", bus.ifid_pc, 32'hffff_fffc);

    // reset mid-drain, then a full drain again
    set_in(1, 0, 0, 0); tick("rst5");
    set_in(0, 0, 0, 0);
    for (int i = 0; i < 6; i++) tick("toh3");
    tick("rd1"); tick("rd2");
    set_in(1, 0, 0, 0); tick("rdr");
    chk("rdr.addr", bus.imem_addr, 32'h0);
    chk("rdr.state", 32'(bus.state_dbg), 32'd0);
    chk("rdr.inst", bus.ifid_inst, NOP);
    set_in(0, 0, 0, 0);
    for (int i = 0; i < 9; i++) tick("redo");
    chk("redo.halted0", 32'(bus.halted), 32'd0);
    tick("redo10");
    chk("redo.halted1", 32'(bus.halted), 32'd1);

    // random traffic
    halt_en = 0;
    for (int i = 0; i < 64; i++) begin
      rom[i] = $urandom;
      if ($urandom_range(0, 15) == 0) rom[i][6:0] = 7'h7f;
    end
    rand_mode = 1;
    set_in(1, 0, 0, 0); tick("rrst");
    for (int i = 0; i < 600; i++) begin
      set_in($urandom_range(0, 39) == 0,
             $urandom_range(0, 3) == 0,
             $urandom_range(0, 9) == 0,
             $urandom_range(0, 255));
      tick("rnd");
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
